// File: rtl/barrett_reduction.sv
// barrett_reduction: multi-cycle x mod Q using a serial mu = floor(2^DW/Q) divider,
// a Barrett quotient estimate and up to two correction subtractions.
module barrett_reduction #(
    parameter int DATA_WIDTH = 48,
    parameter int Q_WIDTH    = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [Q_WIDTH-1:0]    Q,
    output logic                  done,
    output logic [Q_WIDTH-1:0]    data_out
);
    localparam int DW = DATA_WIDTH;
    localparam int QW = Q_WIDTH;
    localparam int RW = QW + 2;
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [2:0] {IDLE, DIV, MUL, SUB, CORR, DONE} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   x_q, x_d;
    logic [QW-1:0]   q_q, q_d;
    logic [QW-1:0]   rem_q, rem_d;
    logic [DW-1:0]   mu_q, mu_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   q_est_q, q_est_d;
    logic [RW-1:0]   r_q, r_d;
    logic [QW-1:0]   data_out_q, data_out_d;
    logic            done_q, done_d;

    logic [QW:0]     rem_sh, rem_nx;
    logic            rem_ge;
    logic [DW-1:0]   mu_nx;
    logic [2*DW-1:0] prod;
    logic [RW-1:0]   r1, r2;

    // Dividend 2^DW is a single 1 followed by DW zeros, fed MSB first.
    assign rem_sh = {rem_q, cnt_q == '0};
    assign rem_ge = rem_sh >= {1'b0, q_q};
    assign rem_nx = rem_ge ? rem_sh - {1'b0, q_q} : rem_sh;
    // Only Q=1 overflows the DW-bit quotient; saturating keeps r in range there.
    assign mu_nx  = mu_q[DW-1] ? '1 : {mu_q[DW-2:0], rem_ge};
    assign prod   = (2*DW)'(x_q) * (2*DW)'(mu_q);
    assign r1     = r_q >= RW'(q_q) ? r_q - RW'(q_q) : r_q;
    assign r2     = r1 >= RW'(q_q) ? r1 - RW'(q_q) : r1;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        q_d        = q_q;
        rem_d      = rem_q;
        mu_d       = mu_q;
        cnt_d      = cnt_q;
        q_est_d    = q_est_q;
        r_d        = r_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = DIV;
                x_d     = data_in;
                q_d     = Q;
                rem_d   = '0;
                mu_d    = '0;
                cnt_d   = '0;
            end
            DIV: begin
                rem_d   = QW'(rem_nx);
                mu_d    = mu_nx;
                cnt_d   = cnt_q + CW'(1);
                state_d = cnt_q == CW'(DW) ? MUL : DIV;
            end
            MUL: begin
                q_est_d = DW'(prod >> DW);
                state_d = SUB;
            end
            SUB: begin
                r_d     = RW'(x_q - q_est_q * DW'(q_q));
                state_d = CORR;
            end
            CORR: begin
                data_out_d = q_q == '0 ? '0 : QW'(r2);
                done_d     = 1'b1;
                state_d    = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            q_q        <= '0;
            rem_q      <= '0;
            mu_q       <= '0;
            cnt_q      <= '0;
            q_est_q    <= '0;
            r_q        <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            q_q        <= q_d;
            rem_q      <= rem_d;
            mu_q       <= mu_d;
            cnt_q      <= cnt_d;
            q_est_q    <= q_est_d;
            r_q        <= r_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

    assign done     = done_q;
    assign data_out = data_out_q;
endmodule

// File: tb/tb_barrett_reduction.sv
// tb_barrett_reduction: scoreboard bench for barrett_reduction; expected result and
// launch cycle are queued at start and matched against each done pulse.
module tb_barrett_reduction;
    localparam int LAT = 52;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [47:0] data_in;
    logic [22:0] Q;
    logic        done;
    logic [22:0] data_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [22:0] d;
        int          t;
    } exp_t;
    exp_t sb[$];

    barrett_reduction dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
        .Q(Q), .done(done), .data_out(data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (done) begin
            if (sb.size() == 0) check("spurious_done", 1, 0);
            else begin
                e = sb.pop_front();
                check("data_out", 64'(data_out), 64'(e.d));
                check("latency", 64'(cyc - e.t), 64'(LAT));
            end
        end
    end

    task automatic wait_idle(input int quiet);
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("timeout", 64'(sb.size()), 0);
            sb.delete();
        end
        repeat (quiet) @(negedge clk);
    endtask

    task automatic launch(input logic [47:0] x, input logic [22:0] q, input logic [22:0] e);
        @(negedge clk);
        data_in = x;
        Q       = q;
        start   = 1'b1;
        sb.push_back('{e, cyc + 1});
        @(negedge clk);
        start   = 1'b0;
        data_in = 48'($urandom);
        Q       = 23'($urandom);
    endtask

    task automatic req(input logic [47:0] x, input logic [22:0] q, input logic [22:0] e);
        launch(x, q, e);
        wait_idle(4);
    endtask

    function automatic logic [22:0] model(input logic [47:0] x, input logic [22:0] q);
        return q == 0 ? 23'd0 : 23'(x % 48'(q));
    endfunction

    initial begin
        logic [63:0] rx;
        logic [22:0] rq;
        int t0;
        rst_n = 1'b0; start = 1'b0; data_in = '0; Q = '0;
        repeat (3) @(negedge clk);
        check("rst_done", 64'(done), 0);
        check("rst_data_out", 64'(data_out), 0);
        #2 rst_n = 1'b1;

        req(48'd65536, 23'd3329, 23'd2285);
        req(48'd16777216, 23'd8380417, 23'd16382);
        req(48'd10000, 23'd4591, 23'd818);
        req(48'hFFFF_FFFF_FFFF, 23'd8380417, 23'd196579);
        req(48'd3328, 23'd3329, 23'd3328);
        req(48'd3329, 23'd3329, 23'd0);
        req(48'd123456, 23'd0, 23'd0);
        req(48'd12345, 23'd1, 23'd0);
        req(48'hFFFF_FFFF_FFFF, 23'd1, 23'd0);
        req(48'hFFFF_FFFF_FFFF, 23'h7FFFFF, model(48'hFFFF_FFFF_FFFF, 23'h7FFFFF));
        req(48'd5, 23'd2, 23'd1);
        for (int i = 0; i < 6; i++) begin
            rx = {32'($urandom), 32'($urandom)};
            rq = 23'($urandom_range(2, 23'h7FFFFF));
            req(rx[47:0], rq, model(rx[47:0], rq));
        end

        // New start mid-DIV with changed operands must be ignored.
        launch(48'd65536, 23'd3329, 23'd2285);
        repeat (10) @(negedge clk);
        data_in = 48'd999999; Q = 23'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(60);

        // start held high across DONE->IDLE relaunches on the first IDLE edge.
        @(negedge clk);
        data_in = 48'd10000; Q = 23'd4591; start = 1'b1;
        t0 = cyc + 1;
        sb.push_back('{23'd818, t0});
        sb.push_back('{23'd818, t0 + LAT + 2});
        repeat (LAT + 3) @(negedge clk);
        start = 1'b0;
        wait_idle(60);

        // Reset dropped while in MUL aborts without a done pulse.
        launch(48'd65536, 23'd3329, 23'd2285);
        repeat (LAT - 3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_done", 64'(done), 0);
        check("abort_data_out", 64'(data_out), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (70) @(negedge clk);
        req(48'd10000, 23'd4591, 23'd818);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/barrett_reduction.md
BARRETT_REDUCTION -- requirements
Module: barrett_reduction

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 48: width of the dividend data_in.
REQ-002 SHALL have parameter Q_WIDTH, default 23: width of the modulus Q and of the result data_out.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request pulse; sampled only in IDLE.
REQ-006 SHALL have port data_in, input, DATA_WIDTH bits: unsigned dividend x.
REQ-007 SHALL have port Q, input, Q_WIDTH bits: unsigned modulus; runtime-variable per request.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port data_out, output, Q_WIDTH bits: x mod Q, registered.

Function
REQ-010 SHALL compute data_out = data_in mod Q exactly for every data_in in [0, 2^DATA_WIDTH-1] and every Q in [2, 2^Q_WIDTH-1].
REQ-011 SHALL latch data_in and Q on the rising edge where start=1 in IDLE; later input changes SHALL NOT affect that result.
REQ-012 SHALL implement the FSM states IDLE -> DIV -> MUL -> SUB -> CORR -> DONE -> IDLE.
REQ-013 DIV SHALL compute mu = floor(2^DATA_WIDTH / Q_latched) with a bit-serial restoring divider producing 1 quotient bit per cycle, for exactly DATA_WIDTH+1 cycles.
- mu is held in a DATA_WIDTH-bit register, which is sufficient because Q>=2.
REQ-014 MUL SHALL form the 2*DATA_WIDTH-bit product x*mu and register q_est = product >> DATA_WIDTH.
REQ-015 SHALL implement SUB and CORR as follows.
- SUB registers r = x - q_est*Q_latched; r < 3*Q, held in at least Q_WIDTH+2 bits.
- CORR performs up to two conditional subtractions of Q, giving 0 <= r < Q.
REQ-016 SHALL assert done for exactly one cycle, on the clock edge DATA_WIDTH+4 cycles after the start-sampling edge (52 cycles at defaults).
- data_out SHALL be updated on that same edge.
REQ-017 data_out SHALL hold its value after done until the next result is written; it SHALL NOT change during computation.
REQ-018 start asserted outside IDLE SHALL be ignored, with no queuing and no restart.
- start held high across DONE->IDLE SHALL launch a new request on the first IDLE edge.
REQ-019 Q_latched = 0 SHALL skip the arithmetic and produce data_out = 0 with the same latency and done pulse.
- Q_latched = 1 SHALL produce data_out = 0 through the normal arithmetic path.
REQ-020 data_in < Q SHALL return data_in unchanged; data_in = Q SHALL return 0.
REQ-021 Latency SHALL be fixed and independent of operand values.

Reset
REQ-022 rst_n=0 SHALL asynchronously force the following, regardless of state, including mid-computation:
- FSM = IDLE.
- done = 0.
- data_out = 0.
- all internal registers = 0.
REQ-023 After rst_n deasserts, the block SHALL accept start on the first rising edge at which start=1.
- Any operation aborted by reset SHALL produce no done pulse.

Verification
REQ-024 data_in=65536, Q=3329, one-cycle start -> done one cycle at 52 cycles, data_out=2285.
REQ-025 data_in=16777216, Q=8380417 -> data_out=16382; data_in=10000, Q=4591 -> data_out=818.
REQ-026 data_in=2^48-1, Q=8380417 -> data_out=196579.
- data_in=3328, Q=3329 -> 3328.
- data_in=3329, Q=3329 -> 0.
REQ-027 Q=0 -> data_out=0 with done at 52 cycles; Q=1 with any data_in -> 0.
REQ-028 Input change and restart handling:
- Change data_in/Q and pulse start during DIV -> original result returned at original latency.
- The second start produces no extra done.
REQ-029 Reset mid-operation:
- Drop rst_n during MUL -> done=0 and data_out=0 immediately; no done follows.
- A subsequent request (10000, 4591) -> 818.
